audio_mix_seq: RTL

- Parametrised, time-multiplexed stereo audio mixer; the successor to the fixed-sum mixing path that feeds the volume control and the i2s/dac outputs in the MSX core.
- Takes NUM_CH source channels (OPLL, OPL3, SCC1/2, PSG, PCM, tape, …), each with its own format flag, gain and mute.
- On each sample strobe it snapshots the channels, accumulates one channel per clock, applies a master volume, then saturates and presents one registered stereo sample.
- Differs from the fixed adder tree in three ways: it supports per-channel gain, it converts unsigned sources, and it reports clipping and overrun.

---
 rtl/audio_mix_pkg.sv | 25 ++
 rtl/mix_saturate.sv | 32 +++
 rtl/audio_mix_seq.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/audio_mix_pkg.sv
// audio_mix_pkg
//   Shared types and constants for the time-multiplexed stereo mixer.
//   - mix_state_t : sequencer states
//   - GAIN_FRAC   : fractional bits of the Q1.3 channel gain
//   - GAIN_UNITY  : gain code for 1.0
//   - VOL_FULL    : master volume code for full scale (no attenuation)
//   - acc_width() : accumulator width that cannot wrap for NUM_CH full-scale terms
package audio_mix_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    SCALE = 2'd2,
    OUT   = 2'd3
  } mix_state_t;

  localparam int GAIN_FRAC  = 3;
  localparam int GAIN_UNITY = 8;
  localparam int VOL_FULL   = 7;

  function automatic int acc_width(input int in_w, input int gain_w, input int num_ch);
    return in_w + gain_w + $clog2(num_ch) + 1;
  endfunction

endpackage

// File: rtl/mix_saturate.sv
// mix_saturate
//   Width-generic signed saturator. Clamps a signed IN_W value into the
//   signed OUT_W range and flags when clamping happened. Purely combinational.
//   Ports:
//     din  in  IN_W   signed value to limit (IN_W > OUT_W)
//     dout out OUT_W  limited value
//     clip out 1      1 when din was outside the OUT_W range
module mix_saturate #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    clip
);

  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    dout = din[OUT_W-1:0];
    clip = 1'b0;
    if (din > MAX_V) begin
      dout = MAX_V[OUT_W-1:0];
      clip = 1'b1;
    end else if (din < MIN_V) begin
      dout = MIN_V[OUT_W-1:0];
      clip = 1'b1;
    end
  end

endmodule

// File: rtl/audio_mix_seq.sv
// audio_mix_seq
//   Time-multiplexed stereo mixer. A sample strobe snapshots every channel,
//   the sequencer accumulates one channel per clock (format conversion, gain,
//   mute), applies the master volume, saturates and registers one stereo sample.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for ce_sample; a strobe snapshots inputs
//   ACC   | adds channel idx (L and R) into the accumulators
//   SCALE | removes gain fraction, applies master volume, aligns to OUT_W
//   OUT   | saturates, registers outputs, pulses out_valid_o
//
//   Ports:
//     clk_sys, res_n          clock, synchronous active-low reset
//     ce_sample               one-cycle sample strobe
//     ch_l_i / ch_r_i         packed channel samples, channel k at [k*IN_W +: IN_W]
//     ch_signed_i             1 = two's complement, 0 = offset binary
//     ch_gain_i               packed Q1.3 gains
//     ch_mute_i               1 = channel contributes 0
//     master_vol_i            0 = mute, 7 = full scale, 6 dB per step
//     out_l_o / out_r_o       mixed sample, held between pulses
//     out_valid_o             one-cycle update pulse
//     clip_l_o / clip_r_o     saturation flags, only high with out_valid_o
//     busy_o                  sample in progress
//     overrun_o               sticky: strobe arrived while busy
module audio_mix_seq
  import audio_mix_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int IN_W   = 16,
  parameter int OUT_W  = 16,
  parameter int GAIN_W = 4
) (
  input  logic                       clk_sys,
  input  logic                       res_n,
  input  logic                       ce_sample,
  input  logic [NUM_CH*IN_W-1:0]     ch_l_i,
  input  logic [NUM_CH*IN_W-1:0]     ch_r_i,
  input  logic [NUM_CH-1:0]          ch_signed_i,
  input  logic [NUM_CH*GAIN_W-1:0]   ch_gain_i,
  input  logic [NUM_CH-1:0]          ch_mute_i,
  input  logic [2:0]                 master_vol_i,
  output logic signed [OUT_W-1:0]    out_l_o,
  output logic signed [OUT_W-1:0]    out_r_o,
  output logic                       out_valid_o,
  output logic                       clip_l_o,
  output logic                       clip_r_o,
  output logic                       busy_o,
  output logic                       overrun_o
);

  localparam int ACC_W  = acc_width(IN_W, GAIN_W, NUM_CH);
  localparam int TERM_W = IN_W + GAIN_W + 1;
  localparam int SC_W   = ACC_W + OUT_W - IN_W;
  localparam int IDX_W  = $clog2(NUM_CH);
  localparam logic [IN_W-1:0] SIGN_BIT = {1'b1, {(IN_W-1){1'b0}}};

  mix_state_t state, state_n;

  logic [NUM_CH*IN_W-1:0]   snap_l, snap_r;
  logic [NUM_CH-1:0]        snap_signed, snap_mute;
  logic [NUM_CH*GAIN_W-1:0] snap_gain;
  logic [2:0]               snap_vol;
  logic [IDX_W-1:0]         idx;
  logic                     idx_last;

  logic signed [ACC_W-1:0]  acc_l, acc_r, acc_l_n, acc_r_n;
  logic signed [SC_W-1:0]   scaled_l, scaled_r, scaled_l_n, scaled_r_n;
  logic signed [OUT_W-1:0]  sat_l, sat_r;
  logic                     sat_clip_l, sat_clip_r;

  logic signed [IN_W-1:0]   x_l, x_r;
  logic signed [GAIN_W:0]   gain_s;
  logic signed [TERM_W-1:0] term_l, term_r;
  logic signed [ACC_W-1:0]  shr_l, shr_r;
  logic [2:0]               vol_sh;

  assign idx_last = (idx == IDX_W'(NUM_CH - 1));
  assign busy_o   = (state != IDLE);

  always_ff @(posedge clk_sys) begin
    if (!res_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (ce_sample) state_n = ACC;
      ACC:     if (idx_last)  state_n = SCALE;
      SCALE:   state_n = OUT;
      OUT:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Current channel term: offset-binary sources flip the MSB to become signed,
  // gain is zero-extended so 15 stays positive.
  always_comb begin
    x_l    = snap_signed[idx] ? snap_l[idx*IN_W +: IN_W] : (snap_l[idx*IN_W +: IN_W] ^ SIGN_BIT);
    x_r    = snap_signed[idx] ? snap_r[idx*IN_W +: IN_W] : (snap_r[idx*IN_W +: IN_W] ^ SIGN_BIT);
    gain_s = {1'b0, snap_gain[idx*GAIN_W +: GAIN_W]};
    term_l = '0;
    term_r = '0;
    if (!snap_mute[idx]) begin
      term_l = TERM_W'(x_l) * TERM_W'(gain_s);
      term_r = TERM_W'(x_r) * TERM_W'(gain_s);
    end
    acc_l_n = acc_l + ACC_W'(term_l);
    acc_r_n = acc_r + ACC_W'(term_r);
  end

  // Gain fraction and volume attenuation are both arithmetic right shifts,
  // so they collapse into one shift chain ahead of the OUT_W alignment.
  always_comb begin
    vol_sh     = 3'(VOL_FULL) - snap_vol;
    shr_l      = (acc_l >>> GAIN_FRAC) >>> vol_sh;
    shr_r      = (acc_r >>> GAIN_FRAC) >>> vol_sh;
    scaled_l_n = '0;
    scaled_r_n = '0;
    if (snap_vol != 3'd0) begin
      scaled_l_n = SC_W'(shr_l) <<< (OUT_W - IN_W);
      scaled_r_n = SC_W'(shr_r) <<< (OUT_W - IN_W);
    end
  end

  mix_saturate #(.IN_W(SC_W), .OUT_W(OUT_W)) u_sat_l (
    .din  (scaled_l),
    .dout (sat_l),
    .clip (sat_clip_l)
  );

  mix_saturate #(.IN_W(SC_W), .OUT_W(OUT_W)) u_sat_r (
    .din  (scaled_r),
    .dout (sat_r),
    .clip (sat_clip_r)
  );

  always_ff @(posedge clk_sys) begin
    if (!res_n) begin
      snap_l      <= '0;
      snap_r      <= '0;
      snap_signed <= '0;
      snap_mute   <= '0;
      snap_gain   <= '0;
      snap_vol    <= '0;
      idx         <= '0;
      acc_l       <= '0;
      acc_r       <= '0;
      scaled_l    <= '0;
      scaled_r    <= '0;
      out_l_o     <= '0;
      out_r_o     <= '0;
      out_valid_o <= 1'b0;
      clip_l_o    <= 1'b0;
      clip_r_o    <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      out_valid_o <= 1'b0;
      clip_l_o    <= 1'b0;
      clip_r_o    <= 1'b0;
      if (ce_sample && state != IDLE) overrun_o <= 1'b1;
      case (state)
        IDLE: begin
          if (ce_sample) begin
            snap_l      <= ch_l_i;
            snap_r      <= ch_r_i;
            snap_signed <= ch_signed_i;
            snap_mute   <= ch_mute_i;
            snap_gain   <= ch_gain_i;
            snap_vol    <= master_vol_i;
            idx         <= '0;
            acc_l       <= '0;
            acc_r       <= '0;
          end
        end
        ACC: begin
          acc_l <= acc_l_n;
          acc_r <= acc_r_n;
          idx   <= idx_last ? '0 : idx + 1'b1;
        end
        SCALE: begin
          scaled_l <= scaled_l_n;
          scaled_r <= scaled_r_n;
        end
        OUT: begin
          out_l_o     <= sat_l;
          out_r_o     <= sat_r;
          clip_l_o    <= sat_clip_l;
          clip_r_o    <= sat_clip_r;
          out_valid_o <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
